// File: rtl/sys_defs_pkg.sv
// Shared system definitions: datapath widths, ROB head entry, CDB payload and commit FSM states.
// Type-only package; no logic, latency or flow control of its own.
package sys_defs;

    localparam int         XLEN        = 32;
    localparam int         ROB_TAG_LEN = 5;
    localparam logic [4:0] ZERO_REG    = 5'd0;

    // For stores, value carries the address and store_value the data.
    typedef struct packed {
        logic            valid;
        logic            wr_mem;
        logic [4:0]      dest_reg;
        logic [XLEN-1:0] value;
        logic [XLEN-1:0] store_value;
    } ROB_ENTRY;

    typedef struct packed {
        logic                   valid;
        logic [ROB_TAG_LEN-1:0] tag;
        logic [XLEN-1:0]        value;
    } CDB_DATA;

    typedef enum logic {
        IDLE       = 1'b0,
        STORE_WAIT = 1'b1
    } COMMIT_STATE;

endpackage

// File: rtl/commit_stage.sv
// In-order retire of the ROB head: ALU ops commit in the same cycle, stores after 1 cycle plus the ack wait.
// Backpressure: an outstanding store blocks head evaluation until mem_ack; mem_req and its payload are held stable.
module commit_stage
    import sys_defs::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  ROB_ENTRY               head_entry,
    input  logic                   head_ready,
    input  logic [ROB_TAG_LEN-1:0] head_tag,
    input  logic                   mem_ack,
    output logic                   commit,
    output logic                   rf_wr_en,
    output logic [4:0]             rf_wr_idx,
    output logic [XLEN-1:0]        rf_wr_data,
    output logic [ROB_TAG_LEN-1:0] rf_wr_tag,
    output logic                   mem_req,
    output logic [XLEN-1:0]        mem_addr,
    output logic [XLEN-1:0]        mem_wdata,
    output logic [CNT_W-1:0]       retired_cnt,
    output logic [CNT_W-1:0]       store_cnt,
    output logic                   busy
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    COMMIT_STATE            r_state;
    logic [XLEN-1:0]        r_mem_addr;
    logic [XLEN-1:0]        r_mem_wdata;
    logic [ROB_TAG_LEN-1:0] r_tag;
    logic [CNT_W-1:0]       r_retired_cnt;
    logic [CNT_W-1:0]       r_store_cnt;

    logic w_idle;
    logic w_head_go;
    logic w_alu_commit;
    logic w_store_commit;
    logic w_commit;

    // Combinational outputs are gated by reset so nothing retires while it is held.
    assign w_idle         = (r_state == IDLE);
    assign w_head_go      = reset & head_entry.valid & head_ready;
    assign w_alu_commit   = w_idle & w_head_go & ~head_entry.wr_mem;
    assign w_store_commit = reset & (r_state == STORE_WAIT) & mem_ack;
    assign w_commit       = w_alu_commit | w_store_commit;

    assign commit      = w_commit;
    assign rf_wr_en    = w_alu_commit & (head_entry.dest_reg != ZERO_REG);
    assign rf_wr_idx   = head_entry.dest_reg;
    assign rf_wr_data  = head_entry.value;
    assign rf_wr_tag   = w_idle ? head_tag : r_tag;
    assign mem_req     = (r_state == STORE_WAIT);
    assign busy        = (r_state == STORE_WAIT);
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign retired_cnt = r_retired_cnt;
    assign store_cnt   = r_store_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_tag         <= '0;
            r_retired_cnt <= '0;
            r_store_cnt   <= '0;
        end else begin
            if (w_commit) begin
                r_retired_cnt <= r_retired_cnt + CNT_ONE;
            end
            case (r_state)
                IDLE: begin
                    if (w_head_go && head_entry.wr_mem) begin
                        r_mem_addr  <= head_entry.value;
                        r_mem_wdata <= head_entry.store_value;
                        r_tag       <= head_tag;
                        r_state     <= STORE_WAIT;
                    end
                end
                STORE_WAIT: begin
                    if (mem_ack) begin
                        r_store_cnt <= r_store_cnt + CNT_ONE;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_commit_stage.sv
// Directed bench for commit_stage: queue-based retire model checked every cycle, plus literal expectations.
// Inputs change 1ns after posedge; all checks happen at or just after negedge.
module tb_commit_stage;
    import sys_defs::*;

    localparam int TB_CNT_W = 4;
    localparam int MOD      = 1 << TB_CNT_W;

    logic                   clock;
    logic                   reset;
    ROB_ENTRY               head_entry;
    logic                   head_ready;
    logic [ROB_TAG_LEN-1:0] head_tag;
    logic                   mem_ack;
    logic                   commit;
    logic                   rf_wr_en;
    logic [4:0]             rf_wr_idx;
    logic [XLEN-1:0]        rf_wr_data;
    logic [ROB_TAG_LEN-1:0] rf_wr_tag;
    logic                   mem_req;
    logic [XLEN-1:0]        mem_addr;
    logic [XLEN-1:0]        mem_wdata;
    logic [TB_CNT_W-1:0]    retired_cnt;
    logic [TB_CNT_W-1:0]    store_cnt;
    logic                   busy;

    int checks   = 0;
    int failures = 0;

    commit_stage #(.CNT_W(TB_CNT_W)) dut (
        .clock(clock), .reset(reset),
        .head_entry(head_entry), .head_ready(head_ready), .head_tag(head_tag), .mem_ack(mem_ack),
        .commit(commit), .rf_wr_en(rf_wr_en), .rf_wr_idx(rf_wr_idx), .rf_wr_data(rf_wr_data),
        .rf_wr_tag(rf_wr_tag), .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .retired_cnt(retired_cnt), .store_cnt(store_cnt), .busy(busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // Model: a pending-store queue (non-empty means a store is outstanding) plus retire totals.
    typedef struct {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
    } store_t;

    store_t pend[$];
    int     m_ret = 0;
    int     m_st  = 0;

    always @(negedge clock) begin
        logic e_commit, e_rf, e_req, hv;
        if (!reset) begin
            pend.delete();
            m_ret = 0;
            m_st  = 0;
            chk("m_rst_commit", 64'(commit), 64'(0));
            chk("m_rst_rfwr", 64'(rf_wr_en), 64'(0));
            chk("m_rst_req", 64'(mem_req), 64'(0));
            chk("m_rst_busy", 64'(busy), 64'(0));
            chk("m_rst_ret", 64'(retired_cnt), 64'(0));
            chk("m_rst_st", 64'(store_cnt), 64'(0));
        end else begin
            hv = head_entry.valid & head_ready;
            if (pend.size() != 0) begin
                e_req    = 1'b1;
                e_commit = mem_ack;
                e_rf     = 1'b0;
            end else begin
                e_req    = 1'b0;
                e_commit = hv & ~head_entry.wr_mem;
                e_rf     = e_commit & (head_entry.dest_reg != 5'd0);
            end
            chk("m_commit", 64'(commit), 64'(e_commit));
            chk("m_rfwr", 64'(rf_wr_en), 64'(e_rf));
            chk("m_req", 64'(mem_req), 64'(e_req));
            chk("m_busy", 64'(busy), 64'(e_req));
            chk("m_ret", 64'(retired_cnt), 64'(m_ret));
            chk("m_st", 64'(store_cnt), 64'(m_st));
            if (e_rf) begin
                chk("m_idx", 64'(rf_wr_idx), 64'(head_entry.dest_reg));
                chk("m_data", 64'(rf_wr_data), 64'(head_entry.value));
                chk("m_tag", 64'(rf_wr_tag), 64'(head_tag));
            end
            if (e_req) begin
                chk("m_addr", 64'(mem_addr), 64'(pend[0].addr));
                chk("m_wdata", 64'(mem_wdata), 64'(pend[0].data));
            end
            if (e_commit) m_ret = (m_ret + 1) % MOD;
            if (pend.size() != 0) begin
                if (mem_ack) begin
                    m_st = (m_st + 1) % MOD;
                    void'(pend.pop_front());
                end
            end else if (hv && head_entry.wr_mem) begin
                pend.push_back('{addr: head_entry.value, data: head_entry.store_value});
            end
        end
    end

    // Drive one cycle of inputs after posedge, then settle just past negedge for literal checks.
    task automatic apply(input logic rst, input logic v, input logic wm, input logic [4:0] d,
                         input logic [31:0] val, input logic [31:0] sv, input logic rdy,
                         input logic [4:0] tg, input logic ack);
        @(posedge clock);
        #1;
        reset            = rst;
        head_entry.valid = v;
        head_entry.wr_mem = wm;
        head_entry.dest_reg = d;
        head_entry.value = val;
        head_entry.store_value = sv;
        head_ready       = rdy;
        head_tag         = tg;
        mem_ack          = ack;
        @(negedge clock);
        #1;
    endtask

    task automatic idle(input logic ack);
        apply(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, ack);
    endtask

    initial begin
        reset      = 1'b0;
        head_entry = '0;
        head_ready = 1'b0;
        head_tag   = '0;
        mem_ack    = 1'b0;

        // Ready ALU head while reset is held must not retire.
        apply(1'b0, 1'b1, 1'b0, 5'd3, 32'd5, 32'd0, 1'b1, 5'd2, 1'b0);
        chk("rst_commit", 64'(commit), 64'(0));
        chk("rst_rfwr", 64'(rf_wr_en), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        idle(1'b0);
        chk("rel_ret", 64'(retired_cnt), 64'(0));

        apply(1'b1, 1'b1, 1'b0, 5'd3, 32'd5, 32'd0, 1'b1, 5'd2, 1'b0);
        chk("alu_commit", 64'(commit), 64'(1));
        chk("alu_rfwr", 64'(rf_wr_en), 64'(1));
        chk("alu_idx", 64'(rf_wr_idx), 64'(3));
        chk("alu_data", 64'(rf_wr_data), 64'(5));
        chk("alu_tag", 64'(rf_wr_tag), 64'(2));
        chk("alu_ret_before", 64'(retired_cnt), 64'(0));
        idle(1'b0);
        chk("alu_ret_after", 64'(retired_cnt), 64'(1));

        apply(1'b1, 1'b1, 1'b0, 5'd0, 32'd7, 32'd0, 1'b1, 5'd3, 1'b0);
        chk("x0_commit", 64'(commit), 64'(1));
        chk("x0_rfwr", 64'(rf_wr_en), 64'(0));
        idle(1'b0);
        chk("x0_ret", 64'(retired_cnt), 64'(2));

        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b1, 1'b0, 5'd4, 32'd9, 32'd0, 1'b0, 5'd4, 1'b0);
            chk("nr_commit", 64'(commit), 64'(0));
            chk("nr_rfwr", 64'(rf_wr_en), 64'(0));
            chk("nr_req", 64'(mem_req), 64'(0));
        end
        chk("nr_ret", 64'(retired_cnt), 64'(2));

        // Store with 3-cycle ack delay; head payload changes while waiting to prove the hold.
        apply(1'b1, 1'b1, 1'b1, 5'd0, 32'h100, 32'hAB, 1'b1, 5'd5, 1'b0);
        chk("st_commit0", 64'(commit), 64'(0));
        chk("st_req0", 64'(mem_req), 64'(0));
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b1, 1'b1, 5'd0, 32'h200, 32'hCD, 1'b1, 5'd5, (i == 2));
            chk("st_req", 64'(mem_req), 64'(1));
            chk("st_addr", 64'(mem_addr), 64'h100);
            chk("st_wdata", 64'(mem_wdata), 64'hAB);
            chk("st_commit", 64'(commit), 64'(i == 2));
            chk("st_rfwr", 64'(rf_wr_en), 64'(0));
        end
        idle(1'b0);
        chk("st_req_drop", 64'(mem_req), 64'(0));
        chk("st_cnt", 64'(store_cnt), 64'(1));
        chk("st_ret", 64'(retired_cnt), 64'(3));

        apply(1'b1, 1'b1, 1'b0, 5'd1, 32'd11, 32'd0, 1'b1, 5'd6, 1'b0);
        chk("b2b_c1", 64'(commit), 64'(1));
        apply(1'b1, 1'b1, 1'b0, 5'd2, 32'd22, 32'd0, 1'b1, 5'd7, 1'b0);
        chk("b2b_c2", 64'(commit), 64'(1));
        chk("b2b_idx2", 64'(rf_wr_idx), 64'(2));
        idle(1'b0);
        chk("b2b_ret", 64'(retired_cnt), 64'(5));

        // Store then a ready ALU: the ALU is ignored until the store has been acked.
        apply(1'b1, 1'b1, 1'b1, 5'd0, 32'h300, 32'h55, 1'b1, 5'd8, 1'b0);
        apply(1'b1, 1'b1, 1'b0, 5'd4, 32'd44, 32'd0, 1'b1, 5'd9, 1'b0);
        chk("sa_wait_commit", 64'(commit), 64'(0));
        chk("sa_wait_rfwr", 64'(rf_wr_en), 64'(0));
        apply(1'b1, 1'b1, 1'b1, 5'd0, 32'h300, 32'h55, 1'b1, 5'd8, 1'b1);
        chk("sa_ack_commit", 64'(commit), 64'(1));
        chk("sa_ack_rfwr", 64'(rf_wr_en), 64'(0));
        apply(1'b1, 1'b1, 1'b0, 5'd4, 32'd44, 32'd0, 1'b1, 5'd9, 1'b0);
        chk("sa_alu_commit", 64'(commit), 64'(1));
        chk("sa_alu_tag", 64'(rf_wr_tag), 64'(9));
        idle(1'b0);
        chk("sa_ret", 64'(retired_cnt), 64'(7));
        chk("sa_st", 64'(store_cnt), 64'(2));

        idle(1'b1);
        chk("idle_ack_commit", 64'(commit), 64'(0));
        chk("idle_ack_busy", 64'(busy), 64'(0));

        // Reset while a store is outstanding abandons it.
        apply(1'b1, 1'b1, 1'b1, 5'd0, 32'h400, 32'h77, 1'b1, 5'd10, 1'b0);
        apply(1'b1, 1'b1, 1'b1, 5'd0, 32'h400, 32'h77, 1'b1, 5'd10, 1'b0);
        chk("mr_busy_pre", 64'(busy), 64'(1));
        apply(1'b0, 1'b1, 1'b1, 5'd0, 32'h400, 32'h77, 1'b1, 5'd10, 1'b1);
        chk("mr_req", 64'(mem_req), 64'(0));
        chk("mr_busy", 64'(busy), 64'(0));
        chk("mr_commit", 64'(commit), 64'(0));
        chk("mr_ret", 64'(retired_cnt), 64'(0));
        chk("mr_st", 64'(store_cnt), 64'(0));
        idle(1'b1);
        chk("mr_spurious_commit", 64'(commit), 64'(0));
        idle(1'b0);

        for (int i = 0; i < 17; i++) begin
            apply(1'b1, 1'b1, 1'b0, 5'd5, 32'(i), 32'd0, 1'b1, 5'd11, 1'b0);
        end
        idle(1'b0);
        chk("wrap_ret", 64'(retired_cnt), 64'(1));
        chk("wrap_st", 64'(store_cnt), 64'(0));

        repeat (2) @(negedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
